// File: rtl/ps2_scancode_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ps2_scancode_ctrl_pkg
// Shared types and constants for the PS/2 scan-code controller.
//   state_e : sequencing FSM states (idle / pop strobe / post-pop gap)
//   act_e   : decode result for one scan-code byte
//   PS2_EXT : extended-key prefix byte
//   PS2_BRK : break (key release) prefix byte
// ----------------------------------------------------------------------------
package ps2_scancode_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ACT_EXT    = 3'd0,  // E0 prefix: remember extension, no event
        ACT_BRK    = 3'd1,  // F0 prefix: remember break, no event
        ACT_MAKE   = 3'd2,  // new key press
        ACT_BREAK  = 3'd3,  // key release sequence completed
        ACT_REPEAT = 3'd4   // typematic repeat of the held key
    } act_e;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

endpackage

// File: rtl/ps2_code_decode.sv
// ----------------------------------------------------------------------------
// ps2_code_decode
// Combinational classification of one scan-code byte against the pending
// prefix flags and the currently held key.
//   code_s        in  : byte popped from the receiver FIFO
//   ext_pend_s    in  : an E0 prefix preceded this byte
//   brk_pend_s    in  : an F0 prefix preceded this byte
//   key_down_s    in  : a key is currently held
//   key_code_s    in  : make code of the held key
//   key_ext_s     in  : held key carried an E0 prefix
//   act_s         out : what the byte means (prefix / make / break / repeat)
//   release_key_s out : break refers to the held key, so it must be released
// ----------------------------------------------------------------------------
module ps2_code_decode
    import ps2_scancode_ctrl_pkg::*;
(
    input  logic [7:0] code_s,
    input  logic       ext_pend_s,
    input  logic       brk_pend_s,
    input  logic       key_down_s,
    input  logic [7:0] key_code_s,
    input  logic       key_ext_s,
    output act_e       act_s,
    output logic       release_key_s
);

    logic held_match_s;

    // Same physical key as the one already held (code and E0 prefix both agree).
    assign held_match_s = key_down_s && (code_s == key_code_s) && (ext_pend_s == key_ext_s);

    // Prefix bytes take priority; otherwise break vs. repeat vs. new make.
    always_comb begin
        act_s         = ACT_MAKE;
        release_key_s = 1'b0;
        if (code_s == PS2_EXT) begin
            act_s = ACT_EXT;
        end else if (code_s == PS2_BRK) begin
            act_s = ACT_BRK;
        end else if (brk_pend_s) begin
            act_s         = ACT_BREAK;
            release_key_s = held_match_s;
        end else if (held_match_s) begin
            act_s = ACT_REPEAT;
        end else begin
            act_s = ACT_MAKE;
        end
    end

endmodule

// File: rtl/ps2_scancode_ctrl.sv
// ----------------------------------------------------------------------------
// ps2_scancode_ctrl
// Pops scan-code bytes from a PS/2 receiver FIFO, assembles E0/F0 prefixed
// sequences and tracks the single currently held key.
//   clk         in  : system clock, rising edge
//   rst         in  : synchronous active-high reset
//   data[7:0]   in  : byte at the FIFO head, valid while ready=1
//   ready       in  : FIFO non-empty
//   overflow    in  : FIFO overflow indication
//   clr_ovf     in  : one-cycle clear request for ovf_flag
//   nextdata_n  out : active-low one-cycle FIFO pop strobe
//   key_code    out : make code of the held key
//   key_ext     out : held key carried an E0 prefix
//   key_down    out : a key is currently held
//   press_cnt   out : count of distinct key presses (wraps)
//   evt         out : one-cycle pulse per completed make/break
//   evt_break   out : qualifies evt (1=break), held until the next evt
//   ovf_flag    out : sticky overflow seen
// Latency: ready seen in IDLE -> byte latched -> POP cycle decode -> evt,
// i.e. evt is visible two cycles after ready is first sampled.
// ----------------------------------------------------------------------------
module ps2_scancode_ctrl
    import ps2_scancode_ctrl_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       data,
    input  logic             ready,
    input  logic             overflow,
    input  logic             clr_ovf,
    output logic             nextdata_n,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_down,
    output logic [CNT_W-1:0] press_cnt,
    output logic             evt,
    output logic             evt_break,
    output logic             ovf_flag
);

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_e           state_r;
    state_e           state_s;
    logic [3:0]       gap_cnt_r;
    logic [7:0]       byte_r;
    logic             ext_pend_r;
    logic             brk_pend_r;
    logic             nextdata_n_r;
    logic [7:0]       key_code_r;
    logic             key_ext_r;
    logic             key_down_r;
    logic [CNT_W-1:0] press_cnt_r;
    logic             evt_r;
    logic             evt_break_r;
    logic             ovf_flag_r;
    act_e             act_s;
    logic             release_key_s;

    assign nextdata_n = nextdata_n_r;
    assign key_code   = key_code_r;
    assign key_ext    = key_ext_r;
    assign key_down   = key_down_r;
    assign press_cnt  = press_cnt_r;
    assign evt        = evt_r;
    assign evt_break  = evt_break_r;
    assign ovf_flag   = ovf_flag_r;

    ps2_code_decode u_decode (
        .code_s        (byte_r),
        .ext_pend_s    (ext_pend_r),
        .brk_pend_s    (brk_pend_r),
        .key_down_s    (key_down_r),
        .key_code_s    (key_code_r),
        .key_ext_s     (key_ext_r),
        .act_s         (act_s),
        .release_key_s (release_key_s)
    );

    // Next-state logic; ready is only looked at in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ready) begin
                    state_s = ST_POP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_POP: begin
                state_s = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_GAP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register, gap counter and the registered pop strobe. The strobe is
    // derived from the next state so it is low exactly during the POP cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            gap_cnt_r    <= 4'd0;
            nextdata_n_r <= 1'b1;
        end else begin
            state_r      <= state_s;
            nextdata_n_r <= (state_s != ST_POP);
            if ((state_r == ST_GAP) && (state_s == ST_GAP)) begin
                gap_cnt_r <= gap_cnt_r + 4'd1;
            end else begin
                gap_cnt_r <= 4'd0;
            end
        end
    end

    // Capture the FIFO head when leaving IDLE; decoded during the POP cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_r <= 8'h00;
        end else if ((state_r == ST_IDLE) && ready) begin
            byte_r <= data;
        end else begin
            byte_r <= byte_r;
        end
    end

    // Key tracking: prefix flags, held key, press counter and event pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_pend_r  <= 1'b0;
            brk_pend_r  <= 1'b0;
            key_code_r  <= 8'h00;
            key_ext_r   <= 1'b0;
            key_down_r  <= 1'b0;
            press_cnt_r <= '0;
            evt_r       <= 1'b0;
            evt_break_r <= 1'b0;
        end else begin
            evt_r <= 1'b0;
            if (state_r == ST_POP) begin
                case (act_s)
                    ACT_EXT: begin
                        ext_pend_r <= 1'b1;
                    end
                    ACT_BRK: begin
                        brk_pend_r <= 1'b1;
                    end
                    ACT_BREAK: begin
                        evt_r       <= 1'b1;
                        evt_break_r <= 1'b1;
                        if (release_key_s) begin
                            key_down_r <= 1'b0;
                        end
                        ext_pend_r <= 1'b0;
                        brk_pend_r <= 1'b0;
                    end
                    ACT_REPEAT: begin
                        ext_pend_r <= 1'b0;
                        brk_pend_r <= 1'b0;
                    end
                    ACT_MAKE: begin
                        key_code_r  <= byte_r;
                        key_ext_r   <= ext_pend_r;
                        key_down_r  <= 1'b1;
                        press_cnt_r <= press_cnt_r + CNT_W'(1);
                        evt_r       <= 1'b1;
                        evt_break_r <= 1'b0;
                        ext_pend_r  <= 1'b0;
                        brk_pend_r  <= 1'b0;
                    end
                    default: begin
                        ext_pend_r <= 1'b0;
                        brk_pend_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Sticky overflow flag; a new overflow beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_flag_r <= 1'b0;
        end else if (overflow) begin
            ovf_flag_r <= 1'b1;
        end else if (clr_ovf) begin
            ovf_flag_r <= 1'b0;
        end else begin
            ovf_flag_r <= ovf_flag_r;
        end
    end

endmodule

// File: tb/tb_ps2_scancode_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ps2_scancode_ctrl
// Drives a behavioural receiver FIFO into ps2_scancode_ctrl. Stimulus pushes
// FIFO bytes plus the expected events into a queue; a monitor pops and
// compares on every evt pulse. A second process checks pop spacing.
// ----------------------------------------------------------------------------
module tb_ps2_scancode_ctrl;

    localparam int CNT_W = 8;
    localparam int GAP   = 2;

    typedef struct packed {
        logic             brk;
        logic [7:0]       code;
        logic             ext;
        logic             down;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       data = 8'h00;
    logic             ready = 1'b0;
    logic             overflow = 1'b0;
    logic             clr_ovf = 1'b0;
    logic             nextdata_n;
    logic [7:0]       key_code;
    logic             key_ext;
    logic             key_down;
    logic [CNT_W-1:0] press_cnt;
    logic             evt;
    logic             evt_break;
    logic             ovf_flag;

    exp_t             exp_q[$];
    logic [7:0]       byte_q[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    int               cyc = 0;
    int               pop_cnt = 0;
    int               last_pop = 0;
    bit               spacing_armed = 1'b0;
    logic [CNT_W-1:0] exp_cnt = '0;

    ps2_scancode_ctrl #(.CNT_W(CNT_W), .GAP_CYCLES(GAP)) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf),
        .nextdata_n (nextdata_n),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_down   (key_down),
        .press_cnt  (press_cnt),
        .evt        (evt),
        .evt_break  (evt_break),
        .ovf_flag   (ovf_flag)
    );

    initial forever #5 clk = ~clk;

    // Cycle counter, advanced on the active edge and read on the falling edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic refresh_fifo();
        ready = (byte_q.size() > 0);
        data  = (byte_q.size() > 0) ? byte_q[0] : 8'h00;
    endtask

    task automatic push_byte(input logic [7:0] b);
        byte_q.push_back(b);
        refresh_fifo();
    endtask

    task automatic exp_make(input logic [7:0] code, input logic ext);
        exp_cnt = exp_cnt + CNT_W'(1);
        exp_q.push_back({1'b0, code, ext, 1'b1, exp_cnt});
    endtask

    // Break reports the key state after the release: code/ext of the held key.
    task automatic exp_break(input logic [7:0] code, input logic ext, input logic down);
        exp_q.push_back({1'b1, code, ext, down, exp_cnt});
    endtask

    task automatic drain(input string name, input int budget);
        int left;
        left = budget;
        while (byte_q.size() > 0 && left > 0) begin
            @(negedge clk);
            left--;
        end
        if (byte_q.size() > 0) check({name, "_drain_timeout"}, byte_q.size(), 0);
        repeat (GAP + 4) @(negedge clk);
        check({name, "_evt_missing"}, exp_q.size(), 0);
    endtask

    // Receiver FIFO model: pop on the strobe, verify back-to-back spacing.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            spacing_armed = 1'b0;
        end else if (nextdata_n == 1'b0) begin
            pop_cnt++;
            if (spacing_armed) check("pop_spacing", cyc - last_pop, GAP + 2);
            last_pop = cyc;
            if (byte_q.size() == 0) begin
                check("pop_on_empty", 1, 0);
            end else begin
                void'(byte_q.pop_front());
            end
            spacing_armed = (byte_q.size() > 0);
            refresh_fifo();
        end
    end

    // Scoreboard monitor: every evt pulse consumes one expected entry.
    initial forever begin
        exp_t got;
        exp_t e;
        @(negedge clk);
        if (!rst && evt === 1'b1) begin
            got = {evt_break, key_code, key_ext, key_down, press_cnt};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL evt_unexpected actual=%h required=none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL evt actual brk/code/ext/down/cnt=%0d/%h/%0d/%0d/%0d required=%0d/%h/%0d/%0d/%0d",
                             got.brk, got.code, got.ext, got.down, got.cnt,
                             e.brk, e.code, e.ext, e.down, e.cnt);
                end
            end
        end
    end

    initial begin
        int c0;
        int p0;
        int left;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_nextdata_n", nextdata_n, 1);
        check("rst_key_code", key_code, 0);
        check("rst_key_down", key_down, 0);
        check("rst_press_cnt", press_cnt, 0);
        check("rst_evt", evt, 0);
        check("rst_ovf_flag", ovf_flag, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1C F0 1C, with ready-to-evt latency on the first byte
        p0 = pop_cnt;
        c0 = cyc;
        push_byte(8'h1C);
        exp_make(8'h1C, 1'b0);
        left = 10;
        do begin
            @(negedge clk);
            left--;
        end while (evt !== 1'b1 && left > 0);
        check("latency", cyc - c0, 2);
        push_byte(8'hF0); push_byte(8'h1C);
        exp_break(8'h1C, 1'b0, 1'b0);
        drain("make_break", 200);
        check("make_break_pops", pop_cnt - p0, 3);

        // Extended key E0 75 / E0 F0 75
        p0 = pop_cnt;
        push_byte(8'hE0); push_byte(8'h75);
        push_byte(8'hE0); push_byte(8'hF0); push_byte(8'h75);
        exp_make(8'h75, 1'b1);
        exp_break(8'h75, 1'b1, 1'b0);
        drain("ext_key", 200);
        check("ext_key_pops", pop_cnt - p0, 5);

        // Typematic repeats produce no event and no count
        p0 = pop_cnt;
        push_byte(8'h1C); push_byte(8'h1C); push_byte(8'h1C);
        push_byte(8'hF0); push_byte(8'h1C);
        exp_make(8'h1C, 1'b0);
        exp_break(8'h1C, 1'b0, 1'b0);
        drain("typematic", 200);
        check("typematic_cnt", press_cnt, 3);

        // Break for a key that is not held leaves the held key alone
        push_byte(8'h2A);
        exp_make(8'h2A, 1'b0);
        push_byte(8'hF0); push_byte(8'h33);
        exp_break(8'h2A, 1'b0, 1'b1);
        push_byte(8'hF0); push_byte(8'h2A);
        exp_break(8'h2A, 1'b0, 1'b0);
        drain("stray_break", 200);

        // Overflow flag: set wins over clear, then clear alone
        overflow = 1'b1; clr_ovf = 1'b1;
        @(negedge clk);
        check("ovf_set_wins", ovf_flag, 1);
        overflow = 1'b0; clr_ovf = 1'b1;
        @(negedge clk);
        check("ovf_cleared", ovf_flag, 0);
        clr_ovf = 1'b0;
        overflow = 1'b1;
        @(negedge clk);
        overflow = 1'b0;
        @(negedge clk);
        check("ovf_sticky", ovf_flag, 1);

        // Reset during the POP of an F0 prefix
        push_byte(8'hF0);
        left = 20;
        do begin
            @(negedge clk);
            left--;
        end while (nextdata_n !== 1'b0 && left > 0);
        check("pop_seen_before_rst", nextdata_n, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_pop_nextdata_n", nextdata_n, 1);
        check("rst_pop_key_code", key_code, 0);
        check("rst_pop_press_cnt", press_cnt, 0);
        check("rst_pop_ovf_flag", ovf_flag, 0);
        check("rst_pop_evt_break", evt_break, 0);
        rst = 1'b0;
        exp_cnt = '0;
        @(negedge clk);
        push_byte(8'h1C);
        exp_make(8'h1C, 1'b0);
        push_byte(8'hF0); push_byte(8'h1C);
        exp_break(8'h1C, 1'b0, 1'b0);
        drain("after_rst", 200);

        // 255 more presses take the counter from 1 through all-ones to 0
        for (int i = 0; i < 255; i++) begin
            push_byte(8'h1C); push_byte(8'hF0); push_byte(8'h1C);
            exp_make(8'h1C, 1'b0);
            exp_break(8'h1C, 1'b0, 1'b0);
        end
        drain("wrap", 5000);
        check("wrap_cnt", press_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_ctrl.md
PS2_SCANCODE_CTRL -- requirements
Module: ps2_scancode_ctrl

Interface
REQ-001 Parameter CNT_W, default 8: width of the key-press counter.
REQ-002 Parameter GAP_CYCLES, default 2: idle cycles after each FIFO pop before ready is re-sampled; legal range 1..15.
REQ-003 clk  in  1  single system clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 data  in  8  scan-code byte at the PS/2 receiver FIFO head; valid while ready=1.
REQ-006 ready  in  1  receiver FIFO non-empty.
REQ-007 overflow  in  1  receiver FIFO overflow indication.
REQ-008 clr_ovf  in  1  one-cycle request to clear ovf_flag.
REQ-009 nextdata_n  out  1  active-low FIFO pop strobe to the receiver.
REQ-010 key_code  out  8  make code of the currently held key.
REQ-011 key_ext  out  1  held key carried an E0 prefix.
REQ-012 key_down  out  1  a key is currently held.
REQ-013 press_cnt  out  CNT_W  count of distinct key presses.
REQ-014 evt  out  1  one-cycle pulse per completed make or break sequence.
REQ-015 evt_break  out  1  qualifies evt: 1=break, 0=make; held until next evt.
REQ-016 ovf_flag  out  1  sticky overflow seen.

Function
REQ-017 The FSM SHALL have states IDLE, POP, GAP.
REQ-018 IDLE: when ready=1, the block SHALL latch data and move to POP; otherwise it SHALL stay in IDLE.
REQ-019 POP: nextdata_n SHALL be 0 for exactly this one cycle; the latched byte SHALL be decoded in this cycle; next state GAP.
REQ-020 GAP: the block SHALL stay GAP_CYCLES cycles with nextdata_n=1, then return to IDLE; ready SHALL be ignored during POP and GAP.
REQ-021 nextdata_n SHALL be 1 in every state other than POP.
REQ-022 Byte 0xE0 SHALL set ext_pend and produce no evt.
REQ-023 Byte 0xF0 SHALL set brk_pend and produce no evt.
REQ-024 Other byte with brk_pend=1 (break): evt=1, evt_break=1; if key_down=1 and code and ext_pend match key_code/key_ext, key_down SHALL clear; ext_pend and brk_pend SHALL clear.
REQ-025 Other byte with brk_pend=0 and key_down=1 matching code/ext (typematic repeat): no evt, no count change; pending flags SHALL clear.
REQ-026 Other byte with brk_pend=0, otherwise (new make): key_code=byte, key_ext=ext_pend, key_down=1, press_cnt+1, evt=1, evt_break=0; pending flags SHALL clear.
REQ-027 press_cnt SHALL wrap from all-ones to 0 without saturating.
REQ-028 Break for a non-held key SHALL still pulse evt with evt_break=1 and leave key_down, key_code unchanged.
REQ-029 ovf_flag SHALL set on any cycle with overflow=1; clr_ovf SHALL clear it; on simultaneous overflow and clr_ovf, set SHALL win.
REQ-030 Total latency ready rise in IDLE -> evt SHALL be 2 cycles (latch, then POP-cycle register).

Reset
REQ-031 rst SHALL force: state=IDLE, nextdata_n=1, key_code=0, key_ext=0, key_down=0, press_cnt=0, evt=0, evt_break=0, ovf_flag=0, ext_pend=0, brk_pend=0, gap counter=0.
REQ-032 rst asserted during POP SHALL deassert the pop at the next edge; a partial E0/F0 sequence SHALL be discarded.

Structure
REQ-033 A shared package SHALL hold the state enum and constants PS2_EXT=8'hE0, PS2_BRK=8'hF0.
REQ-034 Prefix/make/break decode SHALL be a combinational sub-module ps2_code_decode; FSM, counters and output registers stay in ps2_scancode_ctrl.

Verification
REQ-035 FIFO bytes 1C, F0, 1C -> one make evt (key_code=1C, key_down=1, press_cnt=1), one break evt (key_down=0); exactly three one-cycle nextdata_n pulses.
REQ-036 Bytes E0, 75, E0, F0, 75 -> key_ext=1 on make; break clears key_down; both evt pulses correct.
REQ-037 Bytes 1C,1C,1C (typematic) then F0,1C -> press_cnt=1, two evt pulses total.
REQ-038 256 make/break pairs with CNT_W=8 -> press_cnt wraps to 0; ready held high -> pops spaced exactly 1+GAP_CYCLES+1 cycles.
REQ-039 overflow and clr_ovf asserted in the same cycle -> ovf_flag=1; clr_ovf alone next cycle -> 0.
REQ-040 rst during POP after F0 pending -> nextdata_n=1 next cycle, all outputs at reset values, next byte 1C decodes as make.
